mcp3202_channel_scheduler: RTL and testbench
============================================

# mcp3202_channel_scheduler

Shares one MCP3202 ADC between two fixed-channel SPI master instances: channel 0 is `SPI_MCP3202` with SGL=1, ODD=0, and channel 1 is `SPI_MCP3202` with SGL=1, ODD=1. The block paces conversions with a sample-rate timer and grants the SPI pads to one master at a time in round-robin order. It gates each master's EN, waits for DATA_VALID, enforces the CS-high guard time, and presents tagged samples on a one-entry valid/ready output register with sticky error flags.

## Interface
- SAMPLE_DIV, 6250, clocks between sample ticks (20 kS/s aggregate at 125 MHz); must be ≥ 2
- TIMEOUT, 4096, max clocks in CONVERT before abort
- GUARD, 64, min clocks the owner's CS must be high before release (≥ 500 ns at 125 MHz)
- clk  in  1  system clock, 125 MHz
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  global enable for the sample timer
- i_ch_mask  in  2  per-channel enable; bit n enables channel n
- i_ready  in  1  downstream ready
- i_clr  in  1  clears the sticky flags
- i_miso  in  1  ADC DOUT pad
- m0_cs, m0_sck, m0_mosi, m0_valid  in  1 each  channel-0 master outputs
- m0_data  in  12  channel-0 master o_DATA
- m1_cs, m1_sck, m1_mosi, m1_valid, m1_data  same as m0_*, for channel 1
- o_en0, o_en1  out  1 each  master EN
- o_miso0, o_miso1  out  1 each  MISO routed to masters
- o_cs, o_sck, o_mosi  out  1 each  ADC pads
- o_data  out  12  sample
- o_chan  out  1  sample channel
- o_valid  out  1  sample valid
- o_overrun, o_late, o_timeout  out  1 each  sticky error flags
- o_busy  out  1  high when state ≠ IDLE

## Operation
- Sample timer: counts 0..SAMPLE_DIV-1 while i_en is high and pulses tick on wrap. When i_en is low, the counter is held at 0 and pending is cleared.
- pending: set by tick. A tick that arrives while pending is already set sets o_late; ticks are not queued beyond one.
- FSM states: IDLE, CONVERT, RELEASE.
- IDLE:
  - If pending=1 and i_ch_mask=00: clear pending and stay in IDLE.
  - If pending=1 and at least one channel is enabled: pick ch = other(last_ch) if that channel is enabled, else last_ch. Set owner=ch, last_ch=ch, o_en[ch]=1, clear the timeout counter, clear pending, go to CONVERT.
- CONVERT:
  - On mN_valid from the owner: capture mN_data, set o_en[owner]=0, go to RELEASE.
  - Else if the timeout count reaches TIMEOUT-1: set o_en[owner]=0, set o_timeout, capture nothing, go to RELEASE.
  - mN_valid from the non-owner is ignored.
- RELEASE:
  - guard counter increments while the owner's cs=1 and resets to 0 when cs=0.
  - When the count reaches GUARD-1: clear owner_valid, go to IDLE.
- Pad mux (combinational from the owner register):
  - owner_valid=1: o_cs/o_sck/o_mosi come from the owner; o_miso[owner]=i_miso; the non-owner's o_miso=0.
  - owner_valid=0: o_cs=1, o_sck=0, o_mosi=0, both o_miso=0.
- Output register:
  - A capture loads o_data and o_chan and sets o_valid.
  - A handshake (o_valid & i_ready) clears o_valid.
  - Capture in the same cycle as a handshake: the new sample loads and o_valid stays 1.
  - Capture while o_valid=1 with no handshake: the sample is dropped and o_overrun is set.
- Sticky flags: i_clr clears them. If a set event and i_clr occur in the same cycle, set wins.
- i_en deassertion mid-conversion does not abort: the frame completes and its sample is delivered.
- i_ch_mask changes take effect at the next IDLE decision.

## Timing
- Reset values:
  - State IDLE, owner_valid=0, last_ch=1, so the first grant goes to channel 0.
  - o_en0=o_en1=0, o_cs=1, o_sck=0, o_mosi=0, o_miso0=o_miso1=0.
  - o_data=0, o_chan=0, o_valid=0, all flags 0, o_busy=0, counters 0.
- Reset mid-operation returns all outputs to their reset values asynchronously. The pads go idle immediately.
- Latencies:
  - tick → pending: 1 clk.
  - pending → o_en high: 1 clk.
  - mN_valid → o_valid: 1 clk.
  - mN_valid → o_en low: 1 clk.
- Minimum grant-to-grant spacing = conversion time + GUARD + 2 clks.
- All outputs are registered except the pad mux.

## Test plan
- Mask=01, SAMPLE_DIV=6250, model returns 0xD73 → one sample every 6250 clks with o_chan=0 and o_data=0xD73; o_en1 never high; o_cs low only while o_en0 frames.
- Mask=11 → grants alternate ch0, ch1, ch0; pads mirror only the owner; the non-owner's o_miso stays 0.
- i_ready held 0 across two conversions → first sample is held; the second sets o_overrun; i_clr then clears it.
- Master model never asserts valid → o_en drops after TIMEOUT clks, o_timeout=1, o_valid stays 0, FSM returns to IDLE after GUARD.
- SAMPLE_DIV=100 with a 2500-clk conversion → o_late=1 and at most one pending grant; deasserting i_en mid-frame still yields that sample.
- rst_n pulsed low mid-frame → o_cs=1 and o_en0=0 asynchronously, all flags 0; after release the first grant is channel 0.

Source files
------------

// File: rtl/mcp3202_channel_scheduler.sv
// Round-robin scheduler sharing one MCP3202 between two fixed-channel SPI masters:
// paces conversions, gates master EN, muxes the pads and buffers tagged samples.
module mcp3202_channel_scheduler #(
    parameter int unsigned SAMPLE_DIV = 6250,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned GUARD      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [1:0]  i_ch_mask,
    input  logic        i_ready,
    input  logic        i_clr,
    input  logic        i_miso,
    input  logic        m0_cs,
    input  logic        m0_sck,
    input  logic        m0_mosi,
    input  logic        m0_valid,
    input  logic [11:0] m0_data,
    input  logic        m1_cs,
    input  logic        m1_sck,
    input  logic        m1_mosi,
    input  logic        m1_valid,
    input  logic [11:0] m1_data,
    output logic        o_en0,
    output logic        o_en1,
    output logic        o_miso0,
    output logic        o_miso1,
    output logic        o_cs,
    output logic        o_sck,
    output logic        o_mosi,
    output logic [11:0] o_data,
    output logic        o_chan,
    output logic        o_valid,
    output logic        o_overrun,
    output logic        o_late,
    output logic        o_timeout,
    output logic        o_busy
);

    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned GD_W   = $clog2(GUARD + 1);
    localparam int unsigned DATA_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                tick_q, tick_d;
    logic                pending_q, pending_d;
    logic                last_ch_q, last_ch_d;
    logic                owner_q, owner_d;
    logic                owner_valid_q, owner_valid_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [GD_W-1:0]     guard_q, guard_d;
    logic                en0_q, en0_d;
    logic                en1_q, en1_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                chan_q, chan_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                late_q, late_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;

    logic                own_valid_in;
    logic                own_cs_in;
    logic [DATA_W-1:0]   own_data_in;
    logic                other_ch;
    logic                pick_ch;
    logic                consume;
    logic                capture;
    logic                set_overrun;
    logic                set_late;
    logic                set_timeout;

    // Next-state logic for timer, scheduler FSM, output register and flags
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        tick_d        = 1'b0;
        pending_d     = pending_q;
        last_ch_d     = last_ch_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        to_cnt_d      = to_cnt_q;
        guard_d       = guard_q;
        en0_d         = en0_q;
        en1_d         = en1_q;
        data_d        = data_q;
        chan_d        = chan_q;
        valid_d       = valid_q;
        consume       = 1'b0;
        capture       = 1'b0;
        set_overrun   = 1'b0;
        set_timeout   = 1'b0;
        other_ch      = ~last_ch_q;
        pick_ch       = last_ch_q;
        own_valid_in  = owner_q ? m1_valid : m0_valid;
        own_cs_in     = owner_q ? m1_cs : m0_cs;
        own_data_in   = owner_q ? m1_data : m0_data;

        if (i_en) begin
            if (div_cnt_q == DIV_W'(SAMPLE_DIV - 1)) begin
                div_cnt_d = '0;
                tick_d    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            div_cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    consume = 1'b1;
                    if (i_ch_mask != 2'b00) begin
                        pick_ch       = i_ch_mask[other_ch] ? other_ch : last_ch_q;
                        owner_d       = pick_ch;
                        owner_valid_d = 1'b1;
                        last_ch_d     = pick_ch;
                        en0_d         = ~pick_ch;
                        en1_d         = pick_ch;
                        to_cnt_d      = '0;
                        guard_d       = '0;
                        state_d       = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                if (own_valid_in) begin
                    capture = 1'b1;
                    en0_d   = 1'b0;
                    en1_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    set_timeout = 1'b1;
                    en0_d       = 1'b0;
                    en1_d       = 1'b0;
                    state_d     = ST_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RELEASE: begin
                // Guard time counts only consecutive cycles with the owner's CS high
                if (!own_cs_in) begin
                    guard_d = '0;
                end else if (guard_q == GD_W'(GUARD - 1)) begin
                    guard_d       = '0;
                    owner_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    guard_d = guard_q + GD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh tick wins over consumption; only a tick landing on an unconsumed request is late
        set_late = i_en & tick_q & pending_q & ~consume;
        if (!i_en) begin
            pending_d = 1'b0;
        end else if (tick_q) begin
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            if (valid_q && !i_ready) begin
                set_overrun = 1'b1;
            end else begin
                data_d  = own_data_in;
                chan_d  = owner_q;
                valid_d = 1'b1;
            end
        end

        overrun_d = set_overrun | (overrun_q & ~i_clr);
        late_d    = set_late | (late_q & ~i_clr);
        timeout_d = set_timeout | (timeout_q & ~i_clr);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            tick_q        <= 1'b0;
            pending_q     <= 1'b0;
            last_ch_q     <= 1'b1;
            owner_q       <= 1'b0;
            owner_valid_q <= 1'b0;
            to_cnt_q      <= '0;
            guard_q       <= '0;
            en0_q         <= 1'b0;
            en1_q         <= 1'b0;
            data_q        <= '0;
            chan_q        <= 1'b0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            late_q        <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            tick_q        <= tick_d;
            pending_q     <= pending_d;
            last_ch_q     <= last_ch_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            to_cnt_q      <= to_cnt_d;
            guard_q       <= guard_d;
            en0_q         <= en0_d;
            en1_q         <= en1_d;
            data_q        <= data_d;
            chan_q        <= chan_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            late_q        <= late_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    // Pad mux: idle levels whenever no master owns the ADC
    always_comb begin
        o_cs    = 1'b1;
        o_sck   = 1'b0;
        o_mosi  = 1'b0;
        o_miso0 = 1'b0;
        o_miso1 = 1'b0;
        if (owner_valid_q) begin
            o_cs    = owner_q ? m1_cs : m0_cs;
            o_sck   = owner_q ? m1_sck : m0_sck;
            o_mosi  = owner_q ? m1_mosi : m0_mosi;
            o_miso0 = ~owner_q & i_miso;
            o_miso1 = owner_q & i_miso;
        end
    end

    assign o_en0     = en0_q;
    assign o_en1     = en1_q;
    assign o_data    = data_q;
    assign o_chan    = chan_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;
    assign o_late    = late_q;
    assign o_timeout = timeout_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_mcp3202_channel_scheduler.sv
// Bench for mcp3202_channel_scheduler: behavioural master models, a timeline
// reference model checked every cycle, and directed scenario checks.
module tb_mcp3202_channel_scheduler;

    localparam int unsigned SDIV = 100;
    localparam int unsigned TMO  = 400;
    localparam int unsigned GRD  = 8;

    localparam int W_EN0     = 0;
    localparam int W_VALID   = 1;
    localparam int W_OVR     = 2;
    localparam int W_IDLE    = 3;
    localparam int W_LATE    = 4;
    localparam int W_EN0_LOW = 5;
    localparam int W_ANY_EN  = 6;

    logic        clk, rst_n;
    logic        i_en, i_ready, i_clr, i_miso;
    logic [1:0]  i_ch_mask;
    logic        m0_cs, m0_sck, m0_mosi, m0_valid;
    logic [11:0] m0_data;
    logic        m1_cs, m1_sck, m1_mosi, m1_valid;
    logic [11:0] m1_data;
    logic        o_en0, o_en1, o_miso0, o_miso1, o_cs, o_sck, o_mosi;
    logic [11:0] o_data;
    logic        o_chan, o_valid, o_overrun, o_late, o_timeout, o_busy;

    mcp3202_channel_scheduler #(
        .SAMPLE_DIV (SDIV),
        .TIMEOUT    (TMO),
        .GUARD      (GRD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .i_ch_mask (i_ch_mask),
        .i_ready   (i_ready),
        .i_clr     (i_clr),
        .i_miso    (i_miso),
        .m0_cs     (m0_cs),
        .m0_sck    (m0_sck),
        .m0_mosi   (m0_mosi),
        .m0_valid  (m0_valid),
        .m0_data   (m0_data),
        .m1_cs     (m1_cs),
        .m1_sck    (m1_sck),
        .m1_mosi   (m1_mosi),
        .m1_valid  (m1_valid),
        .m1_data   (m1_data),
        .o_en0     (o_en0),
        .o_en1     (o_en1),
        .o_miso0   (o_miso0),
        .o_miso1   (o_miso1),
        .o_cs      (o_cs),
        .o_sck     (o_sck),
        .o_mosi    (o_mosi),
        .o_data    (o_data),
        .o_chan    (o_chan),
        .o_valid   (o_valid),
        .o_overrun (o_overrun),
        .o_late    (o_late),
        .o_timeout (o_timeout),
        .o_busy    (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Master models: a frame of len clocks with CS low, then a one-clock valid
    int len [2];
    int mcyc [2];
    bit hang;

    function automatic logic frame_cs(input logic en, input int c, input int l);
        return !(en && c >= 2 && c <= l);
    endfunction

    initial begin
        mcyc[0] = 0; mcyc[1] = 0;
        m0_cs = 1'b1; m0_sck = 1'b0; m0_mosi = 1'b0; m0_valid = 1'b0;
        m1_cs = 1'b1; m1_sck = 1'b0; m1_mosi = 1'b0; m1_valid = 1'b0;
        i_miso = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mcyc[0]  = (o_en0 === 1'b1) ? mcyc[0] + 1 : 0;
            mcyc[1]  = (o_en1 === 1'b1) ? mcyc[1] + 1 : 0;
            m0_cs    = frame_cs(o_en0 === 1'b1, mcyc[0], len[0]);
            m1_cs    = frame_cs(o_en1 === 1'b1, mcyc[1], len[1]);
            m0_sck   = !m0_cs && (mcyc[0] % 2 == 1);
            m1_sck   = !m1_cs && (mcyc[1] % 2 == 1);
            m0_mosi  = !m0_cs && (mcyc[0] % 4 >= 2);
            m1_mosi  = !m1_cs && (mcyc[1] % 4 >= 2);
            m0_valid = (o_en0 === 1'b1) && !hang && (mcyc[0] == len[0] + 1);
            m1_valid = (o_en1 === 1'b1) && !hang && (mcyc[1] == len[1] + 1);
            i_miso   = 1'($urandom_range(0, 1));
        end
    end

    // Reference model: timeline of ticks, grants, frames and guard windows
    int          m_n_en, m_phase, m_own, m_last, m_tconv, m_run;
    bit          m_tick, m_pend, m_ownv;
    bit [1:0]    m_en;
    logic [11:0] m_dat;
    bit          m_chan, m_vld, m_ovr, m_late, m_tmo;

    task automatic model_reset();
        m_n_en = 0; m_phase = 0; m_own = 0; m_last = 1; m_tconv = 0; m_run = 0;
        m_tick = 0; m_pend = 0; m_ownv = 0; m_en = 2'b00;
        m_dat = 12'h000; m_chan = 0; m_vld = 0; m_ovr = 0; m_late = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        bit tick_now, consume, cap, ev_ovr, ev_late, ev_tmo, vld_old, own_v, own_cs;
        int want;
        logic [11:0] cdat;
        tick_now = m_tick;
        consume = 0; cap = 0; ev_ovr = 0; ev_tmo = 0; cdat = 12'h000;
        own_v  = (m_own == 1) ? m1_valid : m0_valid;
        own_cs = (m_own == 1) ? m1_cs : m0_cs;
        m_n_en = i_en ? m_n_en + 1 : 0;
        m_tick = (m_n_en != 0) && (m_n_en % SDIV == 0);
        case (m_phase)
            0: if (m_pend) begin
                consume = 1;
                if (i_ch_mask != 2'b00) begin
                    want = 1 - m_last;
                    if (!i_ch_mask[want]) want = m_last;
                    m_own = want; m_last = want; m_ownv = 1;
                    m_en = (want == 1) ? 2'b10 : 2'b01;
                    m_phase = 1; m_tconv = 0; m_run = 0;
                end
            end
            1: begin
                m_tconv++;
                if (own_v) begin
                    cap = 1;
                    cdat = (m_own == 1) ? m1_data : m0_data;
                    m_en = 2'b00; m_phase = 2;
                end else if (m_tconv == TMO) begin
                    ev_tmo = 1; m_en = 2'b00; m_phase = 2;
                end
            end
            default: begin
                m_run = own_cs ? m_run + 1 : 0;
                if (m_run == GRD) begin
                    m_ownv = 0; m_phase = 0;
                end
            end
        endcase
        ev_late = i_en && tick_now && m_pend && !consume;
        if (!i_en) m_pend = 0;
        else if (tick_now) m_pend = 1;
        else if (consume) m_pend = 0;
        vld_old = m_vld;
        if (vld_old && i_ready) m_vld = 0;
        if (cap) begin
            if (vld_old && !i_ready) ev_ovr = 1;
            else begin m_dat = cdat; m_chan = (m_own == 1); m_vld = 1; end
        end
        m_ovr  = ev_ovr  || (m_ovr  && !i_clr);
        m_late = ev_late || (m_late && !i_clr);
        m_tmo  = ev_tmo  || (m_tmo  && !i_clr);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) model_reset();
            else model_step();
        end
    end

    // Scenario monitor state
    int          cyc_n = 0;
    int          grants[$];
    int          grant_t[$];
    logic [11:0] s_dat[$];
    bit          s_chan[$];
    bit          en1_seen;
    int          cs_orphan;
    logic        pen0 = 1'b0, pen1 = 1'b0;

    task automatic clear_mon();
        grants.delete(); grant_t.delete(); s_dat.delete(); s_chan.delete();
        en1_seen = 0; cs_orphan = 0;
    endtask

    // Per-cycle compare against the model, plus scenario logging
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (rst_n === 1'b1) begin
                chk("o_en0", 32'(o_en0), 32'(m_en[0]));
                chk("o_en1", 32'(o_en1), 32'(m_en[1]));
                chk("o_busy", 32'(o_busy), 32'(m_phase != 0));
                chk("o_valid", 32'(o_valid), 32'(m_vld));
                chk("o_data", 32'(o_data), 32'(m_dat));
                chk("o_chan", 32'(o_chan), 32'(m_chan));
                chk("o_overrun", 32'(o_overrun), 32'(m_ovr));
                chk("o_late", 32'(o_late), 32'(m_late));
                chk("o_timeout", 32'(o_timeout), 32'(m_tmo));
                chk("o_cs", 32'(o_cs), 32'(m_ownv ? ((m_own == 1) ? m1_cs : m0_cs) : 1'b1));
                chk("o_sck", 32'(o_sck), 32'(m_ownv ? ((m_own == 1) ? m1_sck : m0_sck) : 1'b0));
                chk("o_mosi", 32'(o_mosi), 32'(m_ownv ? ((m_own == 1) ? m1_mosi : m0_mosi) : 1'b0));
                chk("o_miso0", 32'(o_miso0), 32'((m_ownv && m_own == 0) ? i_miso : 1'b0));
                chk("o_miso1", 32'(o_miso1), 32'((m_ownv && m_own == 1) ? i_miso : 1'b0));
                if (o_en0 === 1'b1 && pen0 !== 1'b1) begin grants.push_back(0); grant_t.push_back(cyc_n); end
                if (o_en1 === 1'b1 && pen1 !== 1'b1) begin grants.push_back(1); grant_t.push_back(cyc_n); end
                if (o_en1 === 1'b1) en1_seen = 1;
                if (o_cs === 1'b0 && o_en0 !== 1'b1 && o_en1 !== 1'b1) cs_orphan++;
                if (o_valid === 1'b1 && i_ready === 1'b1) begin s_dat.push_back(o_data); s_chan.push_back(o_chan); end
            end
            pen0 = o_en0;
            pen1 = o_en1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic sig(input int w);
        case (w)
            W_EN0:     return o_en0;
            W_VALID:   return o_valid;
            W_OVR:     return o_overrun;
            W_IDLE:    return !o_busy;
            W_LATE:    return o_late;
            W_EN0_LOW: return !o_en0;
            default:   return o_en0 || o_en1;
        endcase
    endfunction

    task automatic wait_sig(input int w, input int budget, input string nm);
        int i;
        i = 0;
        while (sig(w) !== 1'b1 && i < budget) begin
            step(1);
            i++;
        end
        n_vec++;
        if (sig(w) !== 1'b1) begin
            n_err++;
            $display("FAIL %s: wait expired after %0d cycles, got 0 expected 1", nm, budget);
        end
    endtask

    int n;
    int m;

    initial begin
        rst_n = 1'b0; i_en = 1'b0; i_ch_mask = 2'b00; i_ready = 1'b1; i_clr = 1'b0;
        len[0] = 30; len[1] = 30; hang = 0;
        m0_data = 12'hD73; m1_data = 12'h5A1;
        step(3);
        chk("rst_o_cs", 32'(o_cs), 32'd1);
        chk("rst_o_en0", 32'(o_en0), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_busy", 32'(o_busy), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        rst_n = 1'b1;

        // Single channel: one grant every SAMPLE_DIV clocks, all on channel 0
        clear_mon();
        i_ch_mask = 2'b01; i_en = 1'b1;
        step(360);
        chk("t1_grant_count", 32'(grants.size() >= 3), 32'd1);
        if (grants.size() >= 3) begin
            chk("t1_spacing_a", 32'(grant_t[1] - grant_t[0]), 32'd100);
            chk("t1_spacing_b", 32'(grant_t[2] - grant_t[1]), 32'd100);
            chk("t1_grant_ch", 32'(grants[0] + grants[1] + grants[2]), 32'd0);
        end
        chk("t1_en1_never", 32'(en1_seen), 32'd0);
        chk("t1_cs_orphan", 32'(cs_orphan), 32'd0);
        chk("t1_sample_cnt", 32'(s_dat.size() >= 1), 32'd1);
        if (s_dat.size() >= 1) begin
            chk("t1_sample_data", 32'(s_dat[0]), 32'h0D73);
            chk("t1_sample_chan", 32'(s_chan[0]), 32'd0);
        end
        i_en = 1'b0;
        wait_sig(W_IDLE, 200, "t1_idle");

        // Both channels: channel 0 went last, so the order is 1, 0, 1
        clear_mon();
        i_ch_mask = 2'b11; i_en = 1'b1;
        step(360);
        chk("t2_grant_count", 32'(grants.size() >= 3), 32'd1);
        if (grants.size() >= 3) begin
            chk("t2_grant0", 32'(grants[0]), 32'd1);
            chk("t2_grant1", 32'(grants[1]), 32'd0);
            chk("t2_grant2", 32'(grants[2]), 32'd1);
        end
        chk("t2_sample_cnt", 32'(s_dat.size() >= 3), 32'd1);
        if (s_dat.size() >= 3) begin
            chk("t2_s0", {19'd0, s_chan[0], s_dat[0]}, 32'h00015A1);
            chk("t2_s1", {19'd0, s_chan[1], s_dat[1]}, 32'h0000D73);
            chk("t2_s2", {19'd0, s_chan[2], s_dat[2]}, 32'h00015A1);
        end
        i_en = 1'b0;
        wait_sig(W_IDLE, 200, "t2_idle");

        // Back-pressure: second sample is dropped and flags overrun
        i_ready = 1'b0; i_ch_mask = 2'b01; i_en = 1'b1;
        wait_sig(W_VALID, 300, "t3_first_valid");
        m0_data = 12'hABC;
        wait_sig(W_OVR, 300, "t3_overrun");
        chk("t3_held_data", 32'(o_data), 32'h0D73);
        chk("t3_held_valid", 32'(o_valid), 32'd1);
        i_en = 1'b0;
        wait_sig(W_IDLE, 200, "t3_idle");
        i_clr = 1'b1;
        step(1);
        i_clr = 1'b0;
        chk("t3_ovr_cleared", 32'(o_overrun), 32'd0);
        chk("t3_still_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        step(1);
        chk("t3_drained", 32'(o_valid), 32'd0);
        m0_data = 12'hD73;

        // Master never answers: EN held TIMEOUT clocks, then GUARD clocks of release
        hang = 1; i_en = 1'b1;
        wait_sig(W_EN0, 300, "t4_grant");
        i_en = 1'b0;
        n = 0;
        while (o_en0 === 1'b1 && n < 1000) begin step(1); n++; end
        chk("t4_en_width", 32'(n), 32'd400);
        chk("t4_timeout", 32'(o_timeout), 32'd1);
        chk("t4_no_valid", 32'(o_valid), 32'd0);
        m = 0;
        while (o_busy === 1'b1 && m < 1000) begin step(1); m++; end
        chk("t4_guard", 32'(m), 32'd8);
        hang = 0;
        i_clr = 1'b1;
        step(1);
        i_clr = 1'b0;
        chk("t4_tmo_cleared", 32'(o_timeout), 32'd0);

        // Long frame: late tick, one merged grant, i_en dropped mid-frame still delivers
        clear_mon();
        len[0] = 250; i_en = 1'b1;
        wait_sig(W_LATE, 500, "t5_late");
        chk("t5_late_flag", 32'(o_late), 32'd1);
        wait_sig(W_EN0_LOW, 300, "t5_frame1_end");
        wait_sig(W_EN0, 300, "t5_regrant");
        i_en = 1'b0;
        wait_sig(W_VALID, 400, "t5_sample");
        chk("t5_sample_data", 32'(o_data), 32'h0D73);
        chk("t5_sample_chan", 32'(o_chan), 32'd0);
        wait_sig(W_IDLE, 200, "t5_idle");
        step(150);
        chk("t5_grant_count", 32'(grants.size()), 32'd2);
        len[0] = 30;

        // Reset mid-frame: pads idle and flags clear immediately; first grant is channel 0
        i_ch_mask = 2'b01; i_en = 1'b1;
        wait_sig(W_EN0, 300, "t6_grant");
        step(10);
        chk("t6_pre_late", 32'(o_late), 32'd1);
        chk("t6_pre_cs", 32'(o_cs), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_cs", 32'(o_cs), 32'd1);
        chk("t6_rst_en0", 32'(o_en0), 32'd0);
        chk("t6_rst_flags", {29'd0, o_overrun, o_late, o_timeout}, 32'd0);
        chk("t6_rst_busy", 32'(o_busy), 32'd0);
        step(2);
        i_ch_mask = 2'b11;
        rst_n = 1'b1;
        wait_sig(W_ANY_EN, 300, "t6_first_grant");
        chk("t6_first_en0", 32'(o_en0), 32'd1);
        chk("t6_first_en1", 32'(o_en1), 32'd0);
        wait_sig(W_VALID, 100, "t6_sample");
        chk("t6_sample", {19'd0, o_chan, o_data}, 32'h0000D73);
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
